// File: rtl/apb_pkg.sv
// Shared defaults, state encoding and sizing helper for the APB requester.
package apb_pkg;

  localparam int W_DEFAULT       = 8;
  localparam int D_DEFAULT       = 8;
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Wait-counter width: enough bits to hold TIMEOUT itself, never less than one.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on pready and flags the edge on which the
// count reaches TIMEOUT. With TIMEOUT=0 the timer is removed and never expires.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic preset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int            CW   = cnt_width(TIMEOUT);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      localparam logic [CW-1:0] TOP  = CW'(TIMEOUT);

      logic [CW-1:0] count;

      // NOTE: sequential state is written with non-blocking assignments only,
      // so every flop samples the pre-edge values of its neighbours.
      always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (count_en && (count != TOP)) begin
          count <= count + 1'b1;
        end
      end

      // Combinational so the abort lands on the same edge the count reaches TIMEOUT.
      assign expired = count_en && (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_master.sv
// APB requester: accepts one command at a time, runs SETUP/ACCESS, waits for
// pready (bounded by an optional timeout) and returns a one-cycle response.
module apb_master
  import apb_pkg::*;
#(
  parameter int w       = W_DEFAULT,
  parameter int d       = D_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         preset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [d-1:0] cmd_addr,
  input  logic [w-1:0] cmd_wdata,
  output logic         rsp_valid,
  output logic [w-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         psel,
  output logic         penable,
  output logic         pwrite,
  output logic [d-1:0] paddr,
  output logic [w-1:0] pw_data,
  input  logic [w-1:0] pr_data,
  input  logic         pready,
  input  logic         pslverr
);

  state_t state;
  logic   accept;
  logic   count_en;
  logic   expired;

  // cmd_ready is registered and high exactly in IDLE.
  assign accept   = cmd_valid & cmd_ready;
  assign count_en = (state == ACCESS) & ~pready;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .preset   (preset),
    .clear    (accept),
    .count_en (count_en),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pw_data   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      // NOTE: default-low each cycle makes rsp_valid a single-cycle pulse;
      // rsp_rdata/rsp_err have no default and so hold until the next response.
      rsp_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= SETUP;
            cmd_ready <= 1'b0;
            psel      <= 1'b1;
            pwrite    <= cmd_write;
            paddr     <= cmd_addr;
            pw_data   <= cmd_write ? cmd_wdata : '0;
          end
        end

        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end

        ACCESS: begin
          // pready has priority over a timeout landing on the same edge.
          if (pready) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= pwrite ? '0 : pr_data;
          end else if (expired) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          psel      <= 1'b0;
          penable   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Cycle-driven bench for apb_master: a transaction-level model sets the expected
// outputs for each cycle and a negedge process compares the DUT against them.
module tb_apb_master;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       preset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pw_data, pr_data;
  logic       pready, pslverr;

  always #5 clk = ~clk;

  apb_master #(.w(8), .d(8), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .preset    (preset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pw_data   (pw_data),
    .pr_data   (pr_data),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  typedef struct {
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pw_data;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    bit         bus_care;
  } exp_t;

  exp_t       exp;
  logic [7:0] mem [256];
  logic [7:0] last_rdata;
  logic       last_err;
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    check("psel",      psel,      exp.psel);
    check("penable",   penable,   exp.penable);
    check("cmd_ready", cmd_ready, exp.cmd_ready);
    check("rsp_valid", rsp_valid, exp.rsp_valid);
    check("rsp_rdata", rsp_rdata, exp.rsp_rdata);
    check("rsp_err",   rsp_err,   exp.rsp_err);
    if (exp.bus_care) begin
      check("pwrite",  pwrite,  exp.pwrite);
      check("paddr",   paddr,   exp.paddr);
      check("pw_data", pw_data, exp.pw_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle(input bit rv);
    exp.psel      = 1'b0;
    exp.penable   = 1'b0;
    exp.pwrite    = 1'b0;
    exp.paddr     = 8'h00;
    exp.pw_data   = 8'h00;
    exp.cmd_ready = 1'b1;
    exp.rsp_valid = rv;
    exp.rsp_rdata = last_rdata;
    exp.rsp_err   = last_err;
    exp.bus_care  = 1'b0;
  endtask

  task automatic present(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      set_idle(1'b0);
    end
  endtask

  // One transfer whose command is already presented in the current (idle) cycle.
  // Returns inside the response cycle; with b2b the next command is presented there.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                      input int waits, input logic err,
                      input bit b2b, input logic nwr, input logic [7:0] naddr,
                      input logic [7:0] nwdata);
    bit   abort;
    int   n_acc;
    logic ready;
    abort = (TO > 0) && (waits >= TO);
    n_acc = abort ? TO : waits + 1;

    step();  // SETUP cycle
    cmd_valid = 1'b1;  cmd_write = ~wr;  cmd_addr = ~addr;  cmd_wdata = 8'hEE;
    pready    = 1'b1;  pslverr   = 1'b1; pr_data  = 8'hFF;
    exp.psel      = 1'b1;
    exp.penable   = 1'b0;
    exp.pwrite    = wr;
    exp.paddr     = addr;
    exp.pw_data   = wr ? wdata : 8'h00;
    exp.cmd_ready = 1'b0;
    exp.rsp_valid = 1'b0;
    exp.bus_care  = 1'b1;

    for (int k = 0; k < n_acc; k++) begin
      step();  // ACCESS cycle k
      exp.penable = 1'b1;
      ready   = !abort && (k == waits);
      pready  = ready;
      pslverr = ready ? err : 1'b1;
      pr_data = ready ? (wr ? 8'h99 : mem[addr]) : 8'h77;
    end

    step();  // response cycle
    if (abort) begin
      last_err   = 1'b1;
      last_rdata = 8'h00;
    end else begin
      last_err   = err;
      last_rdata = wr ? 8'h00 : mem[addr];
      if (wr) mem[addr] = wdata;
    end
    pready = 1'b0;  pslverr = 1'b0;  pr_data = 8'h00;
    if (b2b) present(nwr, naddr, nwdata);
    else     cmd_valid = 1'b0;
    set_idle(1'b1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
    preset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    pready = 1'b0; pslverr = 1'b0; pr_data = 8'h00;
    last_rdata = 8'h00;
    last_err   = 1'b0;
    set_idle(1'b0);
    exp.bus_care = 1'b1;  // reset clears pwrite/paddr/pw_data too
    #2  preset = 1'b0;
    #10 preset = 1'b1;
    idle_cycles(2);
    check("reset cmd_ready", cmd_ready, 1'b1);
    check("reset psel",      psel,      1'b0);
    check("reset rsp_rdata", rsp_rdata, 8'h00);

    // Write, zero wait
    present(1'b1, 8'h03, 8'hA5);
    xfer(1'b1, 8'h03, 8'hA5, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("wr0 rsp_valid", rsp_valid, 1'b1);
    check("wr0 rsp_err",   rsp_err,   1'b0);
    check("wr0 rsp_rdata", rsp_rdata, 8'h00);
    idle_cycles(1);

    // Read with two wait states; read data comes from the responder memory
    mem[8'h05] = 8'h3C;
    present(1'b0, 8'h05, 8'h5A);
    xfer(1'b0, 8'h05, 8'h5A, 2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("rd2 rsp_rdata", rsp_rdata, 8'h3C);
    idle_cycles(2);
    check("rd2 rsp_valid single", rsp_valid, 1'b0);
    check("rd2 rdata held",       rsp_rdata, 8'h3C);

    // Slave error, then a clean transfer
    present(1'b1, 8'h17, 8'h42);
    xfer(1'b1, 8'h17, 8'h42, 0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    check("slverr rsp_err", rsp_err, 1'b1);
    idle_cycles(1);
    present(1'b0, 8'h17, 8'h00);
    xfer(1'b0, 8'h17, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("after err rsp_err",   rsp_err,   1'b0);
    check("after err rsp_rdata", rsp_rdata, 8'h42);
    idle_cycles(1);

    // Timeout: pready never arrives
    present(1'b0, 8'h20, 8'h00);
    xfer(1'b0, 8'h20, 8'h00, 100, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("timeout psel",      psel,      1'b0);
    check("timeout rsp_valid", rsp_valid, 1'b1);
    check("timeout rsp_err",   rsp_err,   1'b1);
    check("timeout rsp_rdata", rsp_rdata, 8'h00);
    idle_cycles(1);

    // pready on the edge the counter reaches TIMEOUT completes normally
    present(1'b0, 8'h05, 8'h00);
    xfer(1'b0, 8'h05, 8'h00, TO - 1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("edge rsp_err",   rsp_err,   1'b0);
    check("edge rsp_rdata", rsp_rdata, 8'h3C);
    idle_cycles(1);

    // Back-to-back write then read of address 0
    present(1'b1, 8'h00, 8'h5A);
    xfer(1'b1, 8'h00, 8'h5A, 0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    xfer(1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("b2b rsp_rdata", rsp_rdata, 8'h5A);
    idle_cycles(1);

    // Reset while in ACCESS
    present(1'b1, 8'h30, 8'h11);
    step();
    cmd_valid = 1'b0;
    exp.psel = 1'b1; exp.penable = 1'b0; exp.pwrite = 1'b1; exp.paddr = 8'h30;
    exp.pw_data = 8'h11; exp.cmd_ready = 1'b0; exp.rsp_valid = 1'b0; exp.bus_care = 1'b1;
    step();
    exp.penable = 1'b1;
    #2;
    preset     = 1'b0;
    last_rdata = 8'h00;
    last_err   = 1'b0;
    set_idle(1'b0);
    exp.bus_care = 1'b1;
    #1;
    check("rst psel",      psel,      1'b0);
    check("rst penable",   penable,   1'b0);
    check("rst paddr",     paddr,     8'h00);
    check("rst cmd_ready", cmd_ready, 1'b1);
    check("rst rsp_err",   rsp_err,   1'b0);
    step();
    step();
    #3 preset = 1'b1;
    step();
    step();
    step();
    check("post-rst rsp_valid", rsp_valid, 1'b0);

    // Normal operation resumes after reset
    present(1'b1, 8'h31, 8'h7E);
    xfer(1'b1, 8'h31, 8'h7E, 1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("post-rst wr rsp_err", rsp_err, 1'b0);
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Synthesizable APB requester that drives the existing APB slave.
- Accepts one read or write command at a time on a simple valid/ready command port.
- Sequences the APB SETUP and ACCESS phases, waits for pready, then returns read data and the error flag on a one-cycle response strobe.
- Sits between the system-side control logic and the APB slave bus. It replaces bench-only master code with RTL.

Parameters:
- w, 8, data width of pw_data, pr_data, cmd_wdata and rsp_rdata.
- d, 8, address width of paddr and cmd_addr.
- TIMEOUT, 16, maximum number of ACCESS cycles allowed with pready=0 before the transfer is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- preset  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  d  target address.
- cmd_wdata  in  w  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse marking transfer completion.
- rsp_rdata  out  w  read data; 0 for writes and aborts.
- rsp_err  out  1  pslverr captured at completion, or 1 on timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  d  APB address.
- pw_data  out  w  APB write data; 0 during reads.
- pr_data  in  w  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Behaviour:
- Reset (preset=0, asynchronous):
  - psel, penable, pwrite, paddr, pw_data, rsp_valid, rsp_rdata and rsp_err all go to 0.
  - cmd_ready=1, state=IDLE, wait counter=0.
  - Reset mid-transfer aborts with no response. The bus is idle on the first cycle after reset release.
- States are IDLE, SETUP and ACCESS. All outputs are registered.
- IDLE:
  - cmd_ready=1, psel=0, penable=0.
  - On accept at edge T0: latch cmd_write, cmd_addr and cmd_wdata (forced to 0 if read), then go to SETUP.
- SETUP (cycle T1):
  - psel=1, penable=0; paddr, pwrite and pw_data driven from the latched values.
  - Unconditionally go to ACCESS.
- ACCESS (cycle T2 and later):
  - psel=1, penable=1; paddr, pwrite and pw_data are held stable.
  - Each cycle with pready=0 increments the wait counter and stays in ACCESS.
  - pready=1 sampled at an edge completes the transfer. psel and penable drop to 0 on the next cycle, and state returns to IDLE.
  - In that same next cycle: rsp_valid=1 and rsp_err=pslverr. rsp_rdata=pr_data for reads, 0 for writes.
- Timeout:
  - If TIMEOUT>0 and the wait counter reaches TIMEOUT while pready is still 0, abort.
  - Abort means: psel and penable drop, rsp_valid=1, rsp_err=1, rsp_rdata=0, return to IDLE.
  - A pready=1 on the same edge the counter reaches TIMEOUT counts as a normal completion; pready wins.
- Latency and throughput:
  - Zero wait states gives accept T0, SETUP T1, ACCESS T2, rsp_valid in T3.
  - cmd_ready is high in T3, so a back-to-back command accepted at T3 enters SETUP at T4. Sustained rate is one transfer per 3 cycles.
- Response outputs:
  - rsp_rdata and rsp_err hold their values until the next response.
  - rsp_valid has no backpressure; the consumer must sample it on the pulse.
- pslverr and pr_data are ignored in every cycle except the completing ACCESS edge.
- The wait counter is cleared on entry to SETUP. Its width is clog2(TIMEOUT+1), with a minimum of 1.
- cmd_valid while cmd_ready=0 is ignored; commands are neither queued nor dropped with an error.

Decomposition:
- apb_pkg holds the w and d defaults, the state enum (IDLE, SETUP, ACCESS) and the TIMEOUT default.
- One natural sub-module: apb_wait_timer.
  - Inputs: clk, preset, clear, count_en.
  - Output: expired.
  - Parameterised by TIMEOUT; tied off to expired=0 when TIMEOUT=0.

Test Plan:
- Write, zero wait:
  - Stimulus: cmd write addr=0x03, wdata=0xA5; responder drives pready=1 in the first ACCESS cycle.
  - Required: T1 psel=1 penable=0 paddr=0x03 pw_data=0xA5; T2 penable=1; T3 rsp_valid=1 rsp_err=0 rsp_rdata=0.
- Read with 2 wait states:
  - Stimulus: cmd read addr=0x05; responder holds pready=0 for 2 ACCESS cycles, then pready=1 with pr_data=0x3C.
  - Required: paddr stable at 0x05 throughout; pw_data=0; rsp_valid exactly once with rsp_rdata=0x3C.
- Slave error:
  - Stimulus: write addr=0x17; responder returns pready=1 with pslverr=1.
  - Required: rsp_err=1; the next transfer returns rsp_err=0.
- Timeout:
  - Stimulus: TIMEOUT=4; pready held at 0.
  - Required: exactly 4 ACCESS cycles, then psel=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Back-to-back:
  - Stimulus: cmd_valid held high for write 0x00 then read 0x00, zero wait.
  - Required: second SETUP at T4; read returns the written data from the memory model; no cycle with penable=1 and psel=0.
- Reset mid-ACCESS:
  - Stimulus: drop preset asynchronously between edges while in ACCESS.
  - Required: all outputs go to 0 immediately and cmd_ready=1; no rsp_valid pulse after release.
